// File: rtl/dds_spi_pkg.sv
// rtl/dds_spi_pkg.sv - shared constants, FSM encoding and helpers for the DDS FWORD SPI link
package dds_spi_pkg;

    // SYNC byte plus four fword bytes per frame
    localparam int FRAME_BYTES = 5;

    // default SYNC byte; any value below 8'h80 resets the slave's byte state
    localparam logic [7:0] SYNC_DEFAULT = 8'h00;

    // width of the half-period / gap / hold counters
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_GAP   = 3'd3,
        ST_HOLD  = 3'd4
    } spi_state_t;

    // the slave only accumulates bytes with bit7 set, so every fword byte needs it
    function automatic logic fword_ok(input logic [31:0] fw);
        fword_ok = fw[7] & fw[15] & fw[23] & fw[31];
    endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// rtl/spi_byte_shifter.sv - mode-0 SPI byte engine: SCK timing, tx/rx shift registers, byte_done
module spi_byte_shifter
    import dds_spi_pkg::*;
#(
    parameter int HALF_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_tx_byte,
    input  logic       i_go,
    input  logic       i_miso,
    output logic       o_sck,
    output logic       o_mosi,
    output logic [7:0] o_rx_byte,
    output logic       o_byte_done
);

    logic             r_active;
    logic             r_sck;
    logic [CNT_W-1:0] r_half;
    logic [2:0]       r_bit;
    logic [7:0]       r_tx;
    logic [7:0]       r_rx;

    logic w_half_end;
    logic w_rise;
    logic w_fall;
    logic w_last;

    assign w_half_end  = r_active && (r_half == CNT_W'(HALF_DIV - 1));
    assign w_rise      = w_half_end && !r_sck;
    assign w_fall      = w_half_end && r_sck;
    // last falling edge of bit 0: SCK drops and the engine goes idle on this edge
    assign w_last      = w_fall && (r_bit == 3'd7);

    assign o_sck       = r_sck;
    assign o_mosi      = r_tx[7];
    assign o_rx_byte   = r_rx;
    assign o_byte_done = w_last;

    // SCK half-period timing and bit counting; each byte starts with a full low half
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_active <= 1'b0;
            r_sck    <= 1'b0;
            r_half   <= '0;
            r_bit    <= 3'd0;
        end else if (i_go && !r_active) begin
            r_active <= 1'b1;
            r_sck    <= 1'b0;
            r_half   <= '0;
            r_bit    <= 3'd0;
        end else if (r_active) begin
            if (w_half_end) begin
                r_half <= '0;
                r_sck  <= ~r_sck;
                if (w_fall) begin
                    if (w_last) begin
                        r_active <= 1'b0;
                    end else begin
                        r_bit <= r_bit + 3'd1;
                    end
                end
            end else begin
                r_half <= r_half + CNT_W'(1);
            end
        end
    end

    // tx shifter: load wins; shift on falling edges except after bit 0 so mosi holds until reloaded
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx <= 8'h00;
        end else if (i_load) begin
            r_tx <= i_tx_byte;
        end else if (w_fall && !w_last) begin
            r_tx <= {r_tx[6:0], 1'b0};
        end
    end

    // rx shifter: capture miso MSB first on each rising SCK edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx <= 8'h00;
        end else if (w_rise) begin
            r_rx <= {r_rx[6:0], i_miso};
        end
    end

endmodule

// File: rtl/spi_fword_master.sv
// rtl/spi_fword_master.sv - SPI master sending SYNC + 32-bit DDS fword with echo checking
module spi_fword_master
    import dds_spi_pkg::*;
#(
    parameter int         HALF_DIV   = 2,
    parameter int         GAP_CYCLES = 4,
    parameter logic [7:0] SYNC_BYTE  = SYNC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fword,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        reject,
    output logic        echo_err,
    output logic        cs,
    output logic        sck,
    output logic        mosi,
    input  logic        miso
);

    localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

    spi_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [31:0]      r_fword;
    logic             r_busy;
    logic             r_done;
    logic             r_reject;
    logic             r_echo_err;
    logic             r_cs;

    logic       w_accept;
    logic       w_go;
    logic       w_load;
    logic       w_byte_done;
    logic [7:0] w_load_byte;
    logic [7:0] w_rx_byte;
    logic [7:0] w_expect;

    // frame byte order: SYNC, then fword LSB byte first
    function automatic logic [7:0] tx_byte(input logic [2:0] idx, input logic [31:0] fw);
        case (idx)
            3'd0:    tx_byte = SYNC_BYTE;
            3'd1:    tx_byte = fw[7:0];
            3'd2:    tx_byte = fw[15:8];
            3'd3:    tx_byte = fw[23:16];
            3'd4:    tx_byte = fw[31:24];
            default: tx_byte = 8'h00;
        endcase
    endfunction

    assign w_accept = (r_state == ST_IDLE) && start && fword_ok(fword);
    assign w_go     = ((r_state == ST_SETUP) && (r_cnt == CNT_W'(HALF_DIV - 1))) ||
                      ((r_state == ST_GAP)   && (r_cnt == CNT_W'(GAP_CYCLES - 1)));
    // slave echoes the previous byte plus one
    assign w_expect = 8'(tx_byte(3'(r_idx - 3'd1), r_fword) + 8'd1);

    assign busy     = r_busy;
    assign done     = r_done;
    assign reject   = r_reject;
    assign echo_err = r_echo_err;
    assign cs       = r_cs;

    // next tx byte: SYNC on accept, following byte at each byte end, zero after the last
    always_comb begin
        w_load      = 1'b0;
        w_load_byte = 8'h00;
        if (w_accept) begin
            w_load      = 1'b1;
            w_load_byte = SYNC_BYTE;
        end else if ((r_state == ST_SHIFT) && w_byte_done) begin
            w_load      = 1'b1;
            w_load_byte = (r_idx == LAST_IDX) ? 8'h00 : tx_byte(3'(r_idx + 3'd1), r_fword);
        end
    end

    spi_byte_shifter #(
        .HALF_DIV (HALF_DIV)
    ) u_shifter (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_tx_byte   (w_load_byte),
        .i_go        (w_go),
        .i_miso      (miso),
        .o_sck       (sck),
        .o_mosi      (mosi),
        .o_rx_byte   (w_rx_byte),
        .o_byte_done (w_byte_done)
    );

    // frame sequencer: handshakes, phase timing, echo check, registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_idx      <= 3'd0;
            r_fword    <= 32'h0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_reject   <= 1'b0;
            r_echo_err <= 1'b0;
            r_cs       <= 1'b1;
        end else begin
            r_done   <= 1'b0;
            r_reject <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (fword_ok(fword)) begin
                            r_fword    <= fword;
                            r_idx      <= 3'd0;
                            r_cnt      <= '0;
                            r_busy     <= 1'b1;
                            r_cs       <= 1'b0;
                            r_echo_err <= 1'b0;
                            r_state    <= ST_SETUP;
                        end else begin
                            r_reject <= 1'b1;
                        end
                    end
                end
                ST_SETUP: begin
                    if (r_cnt == CNT_W'(HALF_DIV - 1)) begin
                        r_cnt   <= '0;
                        r_state <= ST_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_SHIFT: begin
                    if (w_byte_done) begin
                        if ((r_idx != 3'd0) && (w_rx_byte != w_expect)) begin
                            r_echo_err <= 1'b1;
                        end
                        r_cnt <= '0;
                        if (r_idx == LAST_IDX) begin
                            r_state <= ST_HOLD;
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_state <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
                        r_cnt   <= '0;
                        r_state <= ST_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == CNT_W'(HALF_DIV - 1)) begin
                        r_cs    <= 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_fword_master.sv
// tb/tb_spi_fword_master.sv - directed self-checking bench for spi_fword_master
module tb_spi_fword_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] fword = 32'h0;
    logic        miso = 1'b0;
    logic        busy, done, reject, echo_err, cs, sck, mosi;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spi_fword_master #(
        .HALF_DIV   (2),
        .GAP_CYCLES (4),
        .SYNC_BYTE  (8'h00)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .fword    (fword),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .reject   (reject),
        .echo_err (echo_err),
        .cs       (cs),
        .sck      (sck),
        .mosi     (mosi),
        .miso     (miso)
    );

    // slave model and line monitor
    logic [7:0] s_tx = 8'hC3;
    logic [7:0] s_rx = 8'h00;
    logic [7:0] s_next = 8'h00;
    logic [7:0] s_bytes [0:4];
    int         s_bit = 0;
    int         s_idx = 0;
    bit         corrupt = 1'b0;
    logic       p_cs = 1'b1, p_sck = 1'b0, p_mosi = 1'b0;
    int         cs_low = 0, rises = 0, mosi_age = 0, viol = 0, done_cnt = 0;

    // echo slave (returns rx+1, first byte 8'hC3) plus SCK/MOSI/CS timing monitor
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (cs && sck) viol++;
        if (mosi !== p_mosi) mosi_age = 0; else mosi_age++;
        if (cs == 1'b0) begin
            if (p_cs) begin
                cs_low = 0; rises = 0; s_tx = 8'hC3; s_bit = 0; s_idx = 0;
                for (int i = 0; i < 5; i++) s_bytes[i] = 8'h5A;
            end
            cs_low++;
        end
        if (sck && !p_sck) begin
            rises++;
            if (mosi_age < 2) viol++;
            s_rx = {s_rx[6:0], mosi};
            s_bit++;
            if (s_bit == 8) begin
                if (s_idx < 5) s_bytes[s_idx] = s_rx;
                s_next = (corrupt && s_idx == 2) ? 8'h00 : 8'(s_rx + 8'd1);
                s_idx++;
                s_bit = 0;
            end
        end
        if (!sck && p_sck) begin
            if (s_bit == 0) s_tx = s_next; else s_tx = {s_tx[6:0], 1'b0};
        end
        miso = s_tx[7];
        p_cs = cs; p_sck = sck; p_mosi = mosi;
    end

    task automatic do_start(input logic [31:0] fw, input int hold);
        @(negedge clk);
        fword = fw;
        start = 1'b1;
        repeat (hold) @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        total++; if (done !== 1'b0)     begin bad++; $display("FAIL reset_done: got %b expected 0", done); end
        total++; if (reject !== 1'b0)   begin bad++; $display("FAIL reset_reject: got %b expected 0", reject); end
        total++; if (echo_err !== 1'b0) begin bad++; $display("FAIL reset_echo_err: got %b expected 0", echo_err); end
        total++; if (cs !== 1'b1)       begin bad++; $display("FAIL reset_cs: got %b expected 1", cs); end
        total++; if (sck !== 1'b0)      begin bad++; $display("FAIL reset_sck: got %b expected 0", sck); end
        total++; if (mosi !== 1'b0)     begin bad++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        bit ok;
        logic [7:0] exp [5];
        exp = '{8'h00, 8'h83, 8'h82, 8'h81, 8'h80};
        do_start(32'h8081_8283, 1);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b expected 1", busy); end
        wait_done(ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL basic_done: got timeout expected done pulse"); end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (s_bytes[i] !== exp[i]) begin bad++; $display("FAIL basic_byte%0d: got %h expected %h", i, s_bytes[i], exp[i]); end
        end
        total++; if (cs_low != 180)   begin bad++; $display("FAIL basic_cs_low: got %0d expected 180", cs_low); end
        total++; if (rises != 40)     begin bad++; $display("FAIL basic_rises: got %0d expected 40", rises); end
        total++; if (echo_err !== 1'b0) begin bad++; $display("FAIL basic_echo_err: got %b expected 0", echo_err); end
        total++; if (busy !== 1'b0)   begin bad++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
        total++; if (cs !== 1'b1)     begin bad++; $display("FAIL basic_cs_end: got %b expected 1", cs); end
        total++; if (reject !== 1'b0) begin bad++; $display("FAIL basic_reject_with_done: got %b expected 0", reject); end
    endtask

    task automatic test_reject;
        do_start(32'h8081_8203, 1);
        total++; if (reject !== 1'b1) begin bad++; $display("FAIL reject_pulse: got %b expected 1", reject); end
        total++; if (cs !== 1'b1)     begin bad++; $display("FAIL reject_cs: got %b expected 1", cs); end
        total++; if (busy !== 1'b0)   begin bad++; $display("FAIL reject_busy: got %b expected 0", busy); end
        total++; if (sck !== 1'b0)    begin bad++; $display("FAIL reject_sck: got %b expected 0", sck); end
        @(negedge clk);
        total++; if (reject !== 1'b0) begin bad++; $display("FAIL reject_one_cycle: got %b expected 0", reject); end
        repeat (4) @(negedge clk);
        total++; if (cs !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL reject_idle: got cs=%b busy=%b expected cs=1 busy=0", cs, busy); end
    endtask

    task automatic test_echo_err;
        bit ok;
        corrupt = 1'b1;
        do_start(32'h8081_8283, 1);
        wait_done(ok);
        corrupt = 1'b0;
        total++; if (ok !== 1'b1)       begin bad++; $display("FAIL echo_done: got timeout expected done pulse"); end
        total++; if (echo_err !== 1'b1) begin bad++; $display("FAIL echo_err_set: got %b expected 1", echo_err); end
        repeat (3) @(negedge clk);
        total++; if (echo_err !== 1'b1) begin bad++; $display("FAIL echo_err_held: got %b expected 1", echo_err); end
        do_start(32'h8081_8283, 1);
        total++; if (echo_err !== 1'b0) begin bad++; $display("FAIL echo_err_clear_on_accept: got %b expected 0", echo_err); end
        wait_done(ok);
        total++; if (ok !== 1'b1)       begin bad++; $display("FAIL echo_clean_done: got timeout expected done pulse"); end
        total++; if (echo_err !== 1'b0) begin bad++; $display("FAIL echo_err_clean: got %b expected 0", echo_err); end
    endtask

    task automatic test_busy_ignore;
        bit ok;
        logic [7:0] exp [5];
        exp = '{8'h00, 8'h83, 8'h82, 8'h81, 8'h80};
        @(negedge clk);
        fword = 32'h8081_8283;
        start = 1'b1;
        repeat (10) @(negedge clk);
        fword = 32'hFFFF_FFFF;
        repeat (140) @(negedge clk);
        start = 1'b0;
        wait_done(ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL ignore_done: got timeout expected done pulse"); end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (s_bytes[i] !== exp[i]) begin bad++; $display("FAIL ignore_byte%0d: got %h expected %h", i, s_bytes[i], exp[i]); end
        end
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0 || cs !== 1'b1) begin bad++; $display("FAIL ignore_no_queue: got busy=%b cs=%b expected busy=0 cs=1", busy, cs); end
        exp = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        do_start(32'hFFFF_FFFF, 1);
        wait_done(ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL ff_done: got timeout expected done pulse"); end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (s_bytes[i] !== exp[i]) begin bad++; $display("FAIL ff_byte%0d: got %h expected %h", i, s_bytes[i], exp[i]); end
        end
        total++; if (echo_err !== 1'b0) begin bad++; $display("FAIL ff_echo_err: got %b expected 0", echo_err); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        bit reached;
        int done0;
        logic [7:0] exp [5];
        exp = '{8'h00, 8'h83, 8'h82, 8'h81, 8'h80};
        do_start(32'h8081_8283, 1);
        reached = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (s_idx == 2) begin reached = 1'b1; break; end
        end
        total++; if (reached !== 1'b1) begin bad++; $display("FAIL mid_reach_idx2: got s_idx=%0d expected 2", s_idx); end
        repeat (20) @(negedge clk);
        done0 = done_cnt;
        #2 rst = 1'b0;
        #1;
        total++; if (cs !== 1'b1)  begin bad++; $display("FAIL mid_async_cs: got %b expected 1", cs); end
        total++; if (sck !== 1'b0) begin bad++; $display("FAIL mid_async_sck: got %b expected 0", sck); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        total++; if (done_cnt != done0) begin bad++; $display("FAIL mid_no_done: got %0d pulses expected %0d", done_cnt, done0); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL mid_busy: got %b expected 0", busy); end
        do_start(32'h8081_8283, 1);
        wait_done(ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL mid_refresh_done: got timeout expected done pulse"); end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (s_bytes[i] !== exp[i]) begin bad++; $display("FAIL mid_byte%0d: got %h expected %h", i, s_bytes[i], exp[i]); end
        end
        total++; if (cs_low != 180) begin bad++; $display("FAIL mid_cs_low: got %0d expected 180", cs_low); end
        total++; if (rises != 40)   begin bad++; $display("FAIL mid_rises: got %0d expected 40", rises); end
    endtask

    task automatic test_timing;
        repeat (4) @(negedge clk);
        total++; if (viol != 0) begin bad++; $display("FAIL timing_violations: got %0d expected 0", viol); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_reject;
        test_echo_err;
        test_busy_ignore;
        test_reset_mid;
        test_timing;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
